// File: rtl/mixer_if_nco.sv
// Windowed edge-count frequency measurement of N_CH RF inputs against a shared
// oscillator; each positive count difference sets an FCW for a per-channel NCO.
module mixer_if_nco #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned WINDOW_LEN  = 1024,
    parameter int unsigned CNT_W       = $clog2(WINDOW_LEN/2+1),
    parameter int unsigned PHASE_W     = 24,
    parameter int unsigned FCW_SHIFT   = 8,
    parameter int unsigned DEFAULT_FCW = 16,
    parameter int unsigned SAMPLE_DIV  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pd,
    input  logic [N_CH-1:0]           rf_in,
    input  logic                      osc_in,
    output logic [N_CH*(CNT_W+1)-1:0] if_cnt,
    output logic [N_CH*PHASE_W-1:0]   fcw,
    output logic                      meas_valid,
    output logic                      sample_en,
    output logic [N_CH*PHASE_W-1:0]   phase
);
    localparam int unsigned WIN_W = $clog2(WINDOW_LEN);
    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned DW    = CNT_W + 1;

    // Bit N_CH of the conditioned vectors is the oscillator.
    logic [N_CH:0]              sync1_q, sync2_q, prev_q, rise;
    logic [CNT_W-1:0]           cnt_q    [N_CH+1];
    logic [CNT_W-1:0]           cnt_d    [N_CH+1];
    logic [DW-1:0]              fin      [N_CH+1];
    logic [WIN_W-1:0]           win_q, win_d;
    logic [DIV_W-1:0]           sdiv_q, sdiv_d;
    logic                       win_end;
    logic                       pend_q, pend_d;
    logic signed [DW-1:0]       diff_q   [N_CH];
    logic signed [DW-1:0]       diff_d   [N_CH];
    logic signed [DW-1:0]       if_cnt_q [N_CH];
    logic signed [DW-1:0]       if_cnt_d [N_CH];
    logic [PHASE_W-1:0]         fcw_q    [N_CH];
    logic [PHASE_W-1:0]         fcw_d    [N_CH];
    logic [PHASE_W-1:0]         phase_q  [N_CH];
    logic [PHASE_W-1:0]         phase_d  [N_CH];
    logic                       meas_valid_q, meas_valid_d;
    logic                       sample_en_q, sample_en_d;

    function automatic logic [PHASE_W-1:0] fcw_rule(input logic signed [DW-1:0] d);
        logic [PHASE_W-1:0] ext;
        ext = PHASE_W'(d);
        return (d > 0) ? (ext << FCW_SHIFT) : PHASE_W'(DEFAULT_FCW);
    endfunction

    assign rise    = sync2_q & ~prev_q;
    assign win_end = (win_q == WIN_W'(WINDOW_LEN - 1));

    // Measurement path: window/divider counters, edge counters, closing difference.
    always_comb begin
        win_d  = win_q;
        sdiv_d = sdiv_q;
        pend_d = 1'b0;
        diff_d = diff_q;
        for (int unsigned i = 0; i <= N_CH; i++) begin
            fin[i]   = DW'(cnt_q[i]) + DW'(rise[i]);
            cnt_d[i] = cnt_q[i];
        end
        if (pd) begin
            win_d  = '0;
            sdiv_d = '0;
            for (int unsigned i = 0; i <= N_CH; i++) cnt_d[i] = '0;
        end else begin
            win_d  = win_end ? '0 : win_q + WIN_W'(1);
            sdiv_d = (sdiv_q == DIV_W'(SAMPLE_DIV - 1)) ? '0 : sdiv_q + DIV_W'(1);
            for (int unsigned i = 0; i <= N_CH; i++)
                cnt_d[i] = win_end ? '0 : cnt_q[i] + CNT_W'(rise[i]);
            if (win_end) begin
                pend_d = 1'b1;
                for (int unsigned c = 0; c < N_CH; c++)
                    diff_d[c] = fin[c] - fin[N_CH];
            end
        end
    end

    // The closing difference is staged one cycle so if_cnt, fcw and meas_valid
    // change together and the new fcw feeds only accumulations after the pulse.
    always_comb begin
        if_cnt_d     = if_cnt_q;
        fcw_d        = fcw_q;
        phase_d      = phase_q;
        meas_valid_d = 1'b0;
        sample_en_d  = 1'b0;
        if (pd) begin
            for (int unsigned c = 0; c < N_CH; c++) fcw_d[c] = PHASE_W'(DEFAULT_FCW);
        end else begin
            sample_en_d = (sdiv_q == DIV_W'(SAMPLE_DIV - 1));
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (sample_en_q) phase_d[c] = phase_q[c] + fcw_q[c];
                if (pend_q) begin
                    if_cnt_d[c] = diff_q[c];
                    fcw_d[c]    = fcw_rule(diff_q[c]);
                end
            end
            meas_valid_d = pend_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            win_q        <= '0;
            sdiv_q       <= '0;
            pend_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            sample_en_q  <= 1'b0;
            for (int unsigned i = 0; i <= N_CH; i++) cnt_q[i] <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                diff_q[c]   <= '0;
                if_cnt_q[c] <= '0;
                fcw_q[c]    <= PHASE_W'(DEFAULT_FCW);
                phase_q[c]  <= '0;
            end
        end else begin
            sync1_q      <= {osc_in, rf_in};
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            win_q        <= win_d;
            sdiv_q       <= sdiv_d;
            pend_q       <= pend_d;
            meas_valid_q <= meas_valid_d;
            sample_en_q  <= sample_en_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            if_cnt_q     <= if_cnt_d;
            fcw_q        <= fcw_d;
            phase_q      <= phase_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign sample_en  = sample_en_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_out
        assign if_cnt[c*DW +: DW]          = if_cnt_q[c];
        assign fcw[c*PHASE_W +: PHASE_W]   = fcw_q[c];
        assign phase[c*PHASE_W +: PHASE_W] = phase_q[c];
    end
endmodule

// File: tb/tb_mixer_if_nco.sv
// Randomised bench for mixer_if_nco: a window-level reference model predicts
// if_cnt/fcw/meas_valid/sample_en/phase every cycle, plus directed scenarios.
module tb_mixer_if_nco;
    localparam int     WL     = 1024;
    localparam int     CW     = $clog2(WL/2+1);
    localparam int     DW     = CW + 1;
    localparam int     PW     = 24;
    localparam longint PH_MOD = 64'sd1 << PW;
    localparam int     WL2    = 16;
    localparam int     DIV2   = 4;
    localparam int     DW2    = $clog2(WL2/2+1) + 1;

    typedef enum {M_PLAN, M_RAND, M_QUIET} mode_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pd  = 1'b0;
    logic [1:0]        rf  = '0;
    logic              osc = 1'b0;
    logic [2*DW-1:0]   if_cnt;
    logic [2*PW-1:0]   fcw;
    logic [2*PW-1:0]   phase;
    logic              mv, se;
    logic              pd2 = 1'b0;
    logic [0:0]        rf2 = '0;
    logic              osc2 = 1'b0;
    logic [DW2-1:0]    if2;
    logic [PW-1:0]     fcw2, phase2;
    logic              mv2, se2;

    mixer_if_nco u_dut (
        .clk(clk), .rst(rst), .pd(pd), .rf_in(rf), .osc_in(osc),
        .if_cnt(if_cnt), .fcw(fcw), .meas_valid(mv), .sample_en(se), .phase(phase)
    );

    mixer_if_nco #(.N_CH(1), .WINDOW_LEN(WL2), .SAMPLE_DIV(DIV2)) u_div (
        .clk(clk), .rst(rst), .pd(pd2), .rf_in(rf2), .osc_in(osc2),
        .if_cnt(if2), .fcw(fcw2), .meas_valid(mv2), .sample_en(se2), .phase(phase2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: t counts active cycles since reset/pd release.
    int         t, t2;
    logic [2:0] last_in, dly0, dly1;
    int         acc [3];
    bit         pend;
    int         pend_diff [2];
    int         exp_if [2];
    longint     exp_fcw [2];
    longint     exp_phase [2];
    bit         exp_mv, exp_se;
    bit         exp2_se, exp2_mv;
    longint     exp2_phase;

    mode_t      m = M_QUIET;
    int         plan_cyc;
    logic [2:0] rnd_val = '0;
    int         hold [3] = '{0, 0, 0};
    logic       race_osc = 1'b0;

    function automatic longint ref_fcw(input int d);
        return (d > 0) ? ((longint'(d) * 256) % PH_MOD) : 64'd16;
    endfunction

    function automatic int get_if(input int c);
        logic signed [DW-1:0] v;
        v = if_cnt[c*DW +: DW];
        return int'(v);
    endfunction

    task automatic model_reset();
        t = 0; t2 = 0; last_in = '0; dly0 = '0; dly1 = '0; pend = 0;
        exp_mv = 0; exp_se = 0; exp2_se = 0; exp2_mv = 0; exp2_phase = 0;
        for (int i = 0; i < 3; i++) acc[i] = 0;
        for (int c = 0; c < 2; c++) begin
            exp_if[c] = 0; exp_fcw[c] = 16; exp_phase[c] = 0; pend_diff[c] = 0;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            chk("if_cnt", get_if(c), exp_if[c]);
            chk("fcw", fcw[c*PW +: PW], exp_fcw[c]);
            chk("phase", phase[c*PW +: PW], exp_phase[c]);
        end
        chk("meas_valid", mv, exp_mv);
        chk("sample_en", se, exp_se);
        chk("div_sample_en", se2, exp2_se);
        chk("div_phase", phase2, exp2_phase);
        chk("div_meas_valid", mv2, exp2_mv);
        chk("div_fcw", fcw2, 16);
        chk("div_if_cnt", if2, 0);
    endtask

    task automatic drive();
        int v;
        case (m)
            M_PLAN: begin
                v = plan_cyc; plan_cyc++;
                rf[0] = ((v / 4) % 2) == 1;
                rf[1] = 1'b0;
                osc   = ((v / 8) % 2) == 1;
            end
            M_RAND: begin
                for (int i = 0; i < 3; i++) begin
                    if (hold[i] == 0) begin
                        rnd_val[i] = ~rnd_val[i];
                        hold[i] = $urandom_range(10, 0);
                    end else hold[i]--;
                end
                rf  = rnd_val[1:0];
                osc = rnd_val[2];
            end
            default: begin
                rf  = '0;
                osc = race_osc;
            end
        endcase
    endtask

    // One clock: advance the model on the edge, check at the falling edge, drive.
    task automatic step();
        logic [2:0] in_now, cnt_rise;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            in_now   = {osc, rf};
            cnt_rise = dly1;
            dly1     = dly0;
            dly0     = in_now & ~last_in;
            last_in  = in_now;
            for (int c = 0; c < 2; c++)
                if (!pd && exp_se) exp_phase[c] = (exp_phase[c] + exp_fcw[c]) % PH_MOD;
            exp_mv = 0;
            if (pd) begin
                t = 0; pend = 0; exp_se = 0;
                for (int i = 0; i < 3; i++) acc[i] = 0;
                for (int c = 0; c < 2; c++) exp_fcw[c] = 16;
            end else begin
                if (pend) begin
                    exp_mv = 1; pend = 0;
                    for (int c = 0; c < 2; c++) begin
                        exp_if[c]  = pend_diff[c];
                        exp_fcw[c] = ref_fcw(pend_diff[c]);
                    end
                end
                t++;
                for (int i = 0; i < 3; i++) acc[i] += int'(cnt_rise[i]);
                if (t % WL == 0) begin
                    pend = 1;
                    for (int c = 0; c < 2; c++) pend_diff[c] = acc[c] - acc[2];
                    for (int i = 0; i < 3; i++) acc[i] = 0;
                end
                exp_se = 1;
            end
            if (exp2_se) exp2_phase = (exp2_phase + 16) % PH_MOD;
            t2++;
            exp2_se = (t2 % DIV2 == 0);
            exp2_mv = (t2 > WL2) && (t2 % WL2 == 1);
        end
        @(negedge clk);
        check_all();
        drive();
    endtask

    task automatic run_to_win(input int target, input string tag);
        int n;
        n = 0;
        while ((t % WL) != target && n < 1200) begin step(); n++; end
        chk(tag, t % WL, target);
    endtask

    task automatic wait_mv(output int n);
        n = 0;
        do begin step(); n++; end while (!mv && n < 1200);
    endtask

    int     n, pulses;
    longint p0, ph_snap;

    initial begin
        model_reset();
        drive();
        #1 rst = 1'b1;
        repeat (4) step();

        // Test-plan stimulus: rf0 period 8, osc period 16, rf1 low.
        m = M_PLAN; plan_cyc = 0;
        rst = 1'b0;
        drive();
        wait_mv(n);
        chk("first_mv_cycle", n, 1025);
        chk("plan_if0_range", (get_if(0) >= 63 && get_if(0) <= 65), 1);
        chk("plan_fcw0_range", (fcw[PW-1:0] >= 16128 && fcw[PW-1:0] <= 16640), 1);
        chk("plan_if1", get_if(1), -64);
        chk("plan_fcw1", fcw[2*PW-1:PW], 16);
        p0 = phase[PW-1:0];
        ph_snap = p0;
        for (int i = 0; i < WL; i++) begin
            step();
            chk("phase_step", (longint'(phase[PW-1:0]) - ph_snap + PH_MOD) % PH_MOD, exp_fcw[0]);
            ph_snap = phase[PW-1:0];
        end
        chk("phase_1024", (longint'(phase[PW-1:0]) - p0 + PH_MOD) % PH_MOD,
            (1024 * ref_fcw(64)) % PH_MOD);
        chk("plan_mv2", mv, 1);

        // Random waveforms over several windows.
        m = M_RAND;
        pulses = 0;
        for (int i = 0; i < 3 * WL; i++) begin step(); pulses += int'(mv); end
        chk("rand_mv_count", pulses, 3);

        // Osc edge detected in the last window cycle belongs to the closing window.
        m = M_QUIET; race_osc = 1'b0;
        run_to_win(0, "race_align");
        run_to_win(WL - 3, "race_pos");
        race_osc = 1'b1;
        drive();
        wait_mv(n);
        chk("race_close_if0", get_if(0), -1);
        chk("race_close_if1", get_if(1), -1);
        wait_mv(n);
        chk("race_next_if0", get_if(0), 0);

        // Power-down mid-window.
        m = M_RAND;
        run_to_win(500, "pd_pos");
        pd = 1'b1;
        ph_snap = phase[PW-1:0];
        pulses = 0;
        for (int i = 0; i < 100; i++) begin step(); pulses += int'(mv) + int'(se); end
        chk("pd_phase_frozen", phase[PW-1:0], ph_snap);
        chk("pd_fcw0", fcw[PW-1:0], 16);
        chk("pd_pulses", pulses, 0);
        pd = 1'b0;
        wait_mv(n);
        chk("pd_release_mv", n, 1025);

        // Asynchronous reset mid-window.
        run_to_win(700, "rst_pos");
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_phase0", phase[PW-1:0], 0);
        repeat (3) step();
        rst = 1'b0;
        wait_mv(n);
        chk("rst_release_mv", n, 1025);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
